// File: rtl/r4_twiddle_mult_stage.sv
// ---------------------------------------------------------------------------
// r4_twiddle_mult_stage
//
// Pipelined complex twiddle multiplier placed after the radix-4 butterfly of
// the 16-point R4MDC FFT. Each valid input cycle carries four complex lanes.
// Lane 0 is only delay-matched. Lanes 1..3 are multiplied by the twiddle words
// that the combinational ROM returns for tw_index. The group counter that
// drives tw_index lives in this block.
//
// Pipeline (3 cycles, no stalls):
//   S1 register inputs, twiddles, valid and sof
//   S2 register the four real partial products of lanes 1..3
//   S3 combine, optionally round, shift by WL-1, saturate and register
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid, in_sof      input group qualifier and first-group-of-frame flag
//   inN_r / inN_i         lane N butterfly output, signed Q1.(WL-1)
//   tw_index              twiddle ROM index (combinational)
//   twN_r / twN_i         ROM words for lanes 1..3, valid in the tw_index cycle
//   out_valid, out_sof    output qualifier and delayed sof
//   outN_r / outN_i       lane N result; data holds while out_valid is low
//
// Build option:
//   TWMUL_ROUND_EN  defined: round half up before the shift
//                   undefined: truncate toward minus infinity
// ---------------------------------------------------------------------------
module r4_twiddle_mult_stage #(
    parameter int WL = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [WL-1:0] in0_r,
    input  logic [WL-1:0] in0_i,
    input  logic [WL-1:0] in1_r,
    input  logic [WL-1:0] in1_i,
    input  logic [WL-1:0] in2_r,
    input  logic [WL-1:0] in2_i,
    input  logic [WL-1:0] in3_r,
    input  logic [WL-1:0] in3_i,
    output logic [1:0]    tw_index,
    input  logic [WL-1:0] tw1_r,
    input  logic [WL-1:0] tw1_i,
    input  logic [WL-1:0] tw2_r,
    input  logic [WL-1:0] tw2_i,
    input  logic [WL-1:0] tw3_r,
    input  logic [WL-1:0] tw3_i,
    output logic          out_valid,
    output logic          out_sof,
    output logic [WL-1:0] out0_r,
    output logic [WL-1:0] out0_i,
    output logic [WL-1:0] out1_r,
    output logic [WL-1:0] out1_i,
    output logic [WL-1:0] out2_r,
    output logic [WL-1:0] out2_i,
    output logic [WL-1:0] out3_r,
    output logic [WL-1:0] out3_i
);

    localparam int PW = 2 * WL;
    localparam int SW = PW + 1;

    typedef logic signed [WL-1:0] word_t;
    typedef logic signed [PW-1:0] prod_t;
    typedef logic signed [SW-1:0] acc_t;

    // Sign-extend a product by one bit so the sum/difference cannot wrap.
    function automatic acc_t sext(input prod_t p);
        sext = {p[PW-1], p};
    endfunction

    // Scale a Q2.(2WL-2) accumulator back to Q1.(WL-1) and clamp it.
    // After the shift the value fits in WL bits only if bits SW-1..WL-1 are
    // all equal; otherwise the sign bit picks the rail.
    function automatic word_t scale_sat(input acc_t acc);
        acc_t sh;
`ifdef TWMUL_ROUND_EN
        sh = (acc + (acc_t'(1) <<< (WL - 2))) >>> (WL - 1);
`else
        sh = acc >>> (WL - 1);
`endif
        if ((&sh[SW-1:WL-1]) || !(|sh[SW-1:WL-1])) begin
            scale_sat = sh[WL-1:0];
        end else if (sh[SW-1]) begin
            scale_sat = {1'b1, {(WL-1){1'b0}}};
        end else begin
            scale_sat = {1'b0, {(WL-1){1'b1}}};
        end
    endfunction

    // ---------------- group counter ----------------
    logic [1:0] grp_q, grp_d;

    // ---------------- S1 ----------------
    word_t s1_x0r_q, s1_x0r_d, s1_x0i_q, s1_x0i_d;
    word_t s1_xr_q[3], s1_xr_d[3], s1_xi_q[3], s1_xi_d[3];
    word_t s1_wr_q[3], s1_wr_d[3], s1_wi_q[3], s1_wi_d[3];
    logic  s1_v_q, s1_v_d, s1_sof_q, s1_sof_d;

    // ---------------- S2 ----------------
    word_t s2_x0r_q, s2_x0r_d, s2_x0i_q, s2_x0i_d;
    prod_t s2_ac_q[3], s2_ac_d[3], s2_bd_q[3], s2_bd_d[3];
    prod_t s2_ad_q[3], s2_ad_d[3], s2_bc_q[3], s2_bc_d[3];
    logic  s2_v_q, s2_v_d, s2_sof_q, s2_sof_d;

    // ---------------- S3 / outputs ----------------
    word_t o0_r_q, o0_r_d, o0_i_q, o0_i_d;
    word_t o_r_q[3], o_r_d[3], o_i_q[3], o_i_d[3];
    logic  o_v_q, o_v_d, o_sof_q, o_sof_d;

    // Group counter and ROM index. A qualified sof forces index 0 for the
    // current group and makes the next group index 1.
    always_comb begin
        grp_d = grp_q;
        if (in_valid) begin
            grp_d = in_sof ? 2'd1 : grp_q + 2'd1;
        end
        tw_index = (in_valid && in_sof) ? 2'd0 : grp_q;
    end

    // S1 capture
    always_comb begin
        s1_x0r_d   = in0_r;
        s1_x0i_d   = in0_i;
        s1_xr_d[0] = in1_r;
        s1_xi_d[0] = in1_i;
        s1_xr_d[1] = in2_r;
        s1_xi_d[1] = in2_i;
        s1_xr_d[2] = in3_r;
        s1_xi_d[2] = in3_i;
        s1_wr_d[0] = tw1_r;
        s1_wi_d[0] = tw1_i;
        s1_wr_d[1] = tw2_r;
        s1_wi_d[1] = tw2_i;
        s1_wr_d[2] = tw3_r;
        s1_wi_d[2] = tw3_i;
        s1_v_d     = in_valid;
        s1_sof_d   = in_valid & in_sof;
    end

    // S2 partial products: (a + jb)(c + jd)
    always_comb begin
        s2_x0r_d = s1_x0r_q;
        s2_x0i_d = s1_x0i_q;
        s2_v_d   = s1_v_q;
        s2_sof_d = s1_sof_q;
        for (int unsigned l = 0; l < 3; l++) begin
            s2_ac_d[l] = prod_t'(s1_xr_q[l]) * prod_t'(s1_wr_q[l]);
            s2_bd_d[l] = prod_t'(s1_xi_q[l]) * prod_t'(s1_wi_q[l]);
            s2_ad_d[l] = prod_t'(s1_xr_q[l]) * prod_t'(s1_wi_q[l]);
            s2_bc_d[l] = prod_t'(s1_xi_q[l]) * prod_t'(s1_wr_q[l]);
        end
    end

    // S3 combine and scale; data only moves on a valid beat.
    always_comb begin
        o0_r_d  = o0_r_q;
        o0_i_d  = o0_i_q;
        o_r_d   = o_r_q;
        o_i_d   = o_i_q;
        o_v_d   = s2_v_q;
        o_sof_d = s2_v_q & s2_sof_q;
        if (s2_v_q) begin
            o0_r_d = s2_x0r_q;
            o0_i_d = s2_x0i_q;
            for (int unsigned l = 0; l < 3; l++) begin
                o_r_d[l] = scale_sat(sext(s2_ac_q[l]) - sext(s2_bd_q[l]));
                o_i_d[l] = scale_sat(sext(s2_ad_q[l]) + sext(s2_bc_q[l]));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grp_q    <= '0;
            s1_x0r_q <= '0;
            s1_x0i_q <= '0;
            s1_xr_q  <= '{default: '0};
            s1_xi_q  <= '{default: '0};
            s1_wr_q  <= '{default: '0};
            s1_wi_q  <= '{default: '0};
            s1_v_q   <= 1'b0;
            s1_sof_q <= 1'b0;
            s2_x0r_q <= '0;
            s2_x0i_q <= '0;
            s2_ac_q  <= '{default: '0};
            s2_bd_q  <= '{default: '0};
            s2_ad_q  <= '{default: '0};
            s2_bc_q  <= '{default: '0};
            s2_v_q   <= 1'b0;
            s2_sof_q <= 1'b0;
            o0_r_q   <= '0;
            o0_i_q   <= '0;
            o_r_q    <= '{default: '0};
            o_i_q    <= '{default: '0};
            o_v_q    <= 1'b0;
            o_sof_q  <= 1'b0;
        end else begin
            grp_q    <= grp_d;
            s1_x0r_q <= s1_x0r_d;
            s1_x0i_q <= s1_x0i_d;
            s1_xr_q  <= s1_xr_d;
            s1_xi_q  <= s1_xi_d;
            s1_wr_q  <= s1_wr_d;
            s1_wi_q  <= s1_wi_d;
            s1_v_q   <= s1_v_d;
            s1_sof_q <= s1_sof_d;
            s2_x0r_q <= s2_x0r_d;
            s2_x0i_q <= s2_x0i_d;
            s2_ac_q  <= s2_ac_d;
            s2_bd_q  <= s2_bd_d;
            s2_ad_q  <= s2_ad_d;
            s2_bc_q  <= s2_bc_d;
            s2_v_q   <= s2_v_d;
            s2_sof_q <= s2_sof_d;
            o0_r_q   <= o0_r_d;
            o0_i_q   <= o0_i_d;
            o_r_q    <= o_r_d;
            o_i_q    <= o_i_d;
            o_v_q    <= o_v_d;
            o_sof_q  <= o_sof_d;
        end
    end

    assign out_valid = o_v_q;
    assign out_sof   = o_sof_q;
    assign out0_r    = o0_r_q;
    assign out0_i    = o0_i_q;
    assign out1_r    = o_r_q[0];
    assign out1_i    = o_i_q[0];
    assign out2_r    = o_r_q[1];
    assign out2_i    = o_i_q[1];
    assign out3_r    = o_r_q[2];
    assign out3_i    = o_i_q[2];

endmodule

// File: tb/tb_r4_twiddle_mult_stage.sv
// ---------------------------------------------------------------------------
// Testbench for r4_twiddle_mult_stage (WL = 16). Directed vectors with
// hand-computed results; the driver pushes expected beats into a queue and
// a negedge monitor pops and compares whenever out_valid is high, and checks
// data hold / out_sof low otherwise. Honors TWMUL_ROUND_EN like the RTL.
// ---------------------------------------------------------------------------
module tb_r4_twiddle_mult_stage;

    localparam int WL = 16;

`ifdef TWMUL_ROUND_EN
    localparam logic [15:0] R1  = 16'h4000;
    localparam logic [15:0] BIM = 16'hd2bf;
    localparam logic [15:0] D2R = 16'h0001;
    localparam logic [15:0] D2I = 16'h0000;
`else
    localparam logic [15:0] R1  = 16'h3fff;
    localparam logic [15:0] BIM = 16'hd2be;
    localparam logic [15:0] D2R = 16'h0000;
    localparam logic [15:0] D2I = 16'hffff;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid, in_sof;
    logic [15:0] in0_r, in0_i, in1_r, in1_i, in2_r, in2_i, in3_r, in3_i;
    logic [15:0] tw1_r, tw1_i, tw2_r, tw2_i, tw3_r, tw3_i;
    logic [1:0]  tw_index;
    logic        out_valid, out_sof;
    logic [15:0] out0_r, out0_i, out1_r, out1_i, out2_r, out2_i, out3_r, out3_i;

    always #5 clk = ~clk;

    r4_twiddle_mult_stage #(.WL(WL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in0_r(in0_r), .in0_i(in0_i), .in1_r(in1_r), .in1_i(in1_i),
        .in2_r(in2_r), .in2_i(in2_i), .in3_r(in3_r), .in3_i(in3_i),
        .tw_index(tw_index),
        .tw1_r(tw1_r), .tw1_i(tw1_i), .tw2_r(tw2_r), .tw2_i(tw2_i),
        .tw3_r(tw3_r), .tw3_i(tw3_i),
        .out_valid(out_valid), .out_sof(out_sof),
        .out0_r(out0_r), .out0_i(out0_i), .out1_r(out1_r), .out1_i(out1_i),
        .out2_r(out2_r), .out2_i(out2_i), .out3_r(out3_r), .out3_i(out3_i)
    );

    // xr/xi/er/ei index = lane; wr/wi index 0..2 = lanes 1..3
    typedef struct packed {
        logic [3:0][15:0] xr;
        logic [3:0][15:0] xi;
        logic [2:0][15:0] wr;
        logic [2:0][15:0] wi;
        logic [3:0][15:0] er;
        logic [3:0][15:0] ei;
    } vec_t;

    typedef struct packed {
        logic [3:0][15:0] r;
        logic [3:0][15:0] i;
        logic             sof;
        logic [31:0]      cyc;
    } exp_t;

    vec_t vtab[5];
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic rst_d  = 1'b1;

    logic [3:0][15:0] last_r = '0;
    logic [3:0][15:0] last_i = '0;
    logic [3:0][15:0] act_r, act_i;
    exp_t             e;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= rst;
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        act_r = {out3_r, out2_r, out1_r, out0_r};
        act_i = {out3_i, out2_i, out1_i, out0_i};
        if (rst_d) begin
            last_r = '0;
            last_i = '0;
        end
        if (out_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid cyc %0d got r=%h i=%h sof=%b want no beat",
                         cyc, act_r, act_i, out_sof);
            end else begin
                e = q.pop_front();
                if (act_r !== e.r || act_i !== e.i || out_sof !== e.sof || cyc != int'(e.cyc)) begin
                    errors++;
                    $display("FAIL out_beat cyc %0d got r=%h i=%h sof=%b want r=%h i=%h sof=%b cyc %0d",
                             cyc, act_r, act_i, out_sof, e.r, e.i, e.sof, e.cyc);
                end
                last_r = e.r;
                last_i = e.i;
            end
        end else begin
            checks++;
            if (out_valid !== 1'b0 || out_sof !== 1'b0 || act_r !== last_r || act_i !== last_i) begin
                errors++;
                $display("FAIL idle_hold cyc %0d got v=%b sof=%b r=%h i=%h want v=0 sof=0 r=%h i=%h",
                         cyc, out_valid, out_sof, act_r, act_i, last_r, last_i);
            end
        end
    end

    task automatic chk_idx(input logic [1:0] want, input string nm);
        checks++;
        if (tw_index !== want) begin
            errors++;
            $display("FAIL %s tw_index got %0d want %0d", nm, tw_index, want);
        end
    endtask

    // Drive one group; optionally record its expected beat, optionally
    // assert reset in the same cycle (index not checked then).
    task automatic send(input int v, input logic sof, input logic [1:0] idx,
                        input bit push, input bit do_rst);
        in_valid = 1'b1;
        in_sof   = sof;
        rst      = do_rst;
        in0_r = vtab[v].xr[0]; in0_i = vtab[v].xi[0];
        in1_r = vtab[v].xr[1]; in1_i = vtab[v].xi[1];
        in2_r = vtab[v].xr[2]; in2_i = vtab[v].xi[2];
        in3_r = vtab[v].xr[3]; in3_i = vtab[v].xi[3];
        tw1_r = vtab[v].wr[0]; tw1_i = vtab[v].wi[0];
        tw2_r = vtab[v].wr[1]; tw2_i = vtab[v].wi[1];
        tw3_r = vtab[v].wr[2]; tw3_i = vtab[v].wi[2];
        #1;
        if (!do_rst) chk_idx(idx, "tw_index");
        if (push) q.push_back('{r: vtab[v].er, i: vtab[v].ei, sof: sof, cyc: 32'(cyc + 3)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 5; k++) vtab[k] = '0;
        // V0: all lanes 0x4000, twiddles 0x7fff
        for (int l = 0; l < 4; l++) vtab[0].xr[l] = 16'h4000;
        for (int l = 0; l < 3; l++) vtab[0].wr[l] = 16'h7fff;
        vtab[0].er = {R1, R1, R1, 16'h4000};
        // V1: lane2 0x4000 x (0x5a82 + j0xa57d)
        vtab[1].xr[0] = 16'h1234; vtab[1].xi[0] = 16'h8765;
        vtab[1].xr[2] = 16'h4000;
        vtab[1].wr = {16'h7fff, 16'h5a82, 16'h7fff};
        vtab[1].wi[1] = 16'ha57d;
        vtab[1].er = {16'h0000, 16'h2d41, 16'h0000, 16'h1234};
        vtab[1].ei = {16'h0000, BIM, 16'h0000, 16'h8765};
        // V2: saturation corners
        vtab[2].xr = {16'h8000, 16'h8000, 16'h8000, 16'h8000};
        vtab[2].xi = {16'h8000, 16'h0000, 16'h0000, 16'h7fff};
        vtab[2].wr = {16'h7fff, 16'h0000, 16'h8000};
        vtab[2].wi = {16'h8000, 16'h8000, 16'h0000};
        vtab[2].er = {16'h8000, 16'h0000, 16'h7fff, 16'h8000};
        vtab[2].ei = {16'h0001, 16'h7fff, 16'h0000, 16'h7fff};
        // V3: exact mid-range product and a rounding-sensitive lane
        vtab[3].xr = {16'h0000, 16'h0001, 16'h2000, 16'h0001};
        vtab[3].xi = {16'h0000, 16'h0000, 16'h1000, 16'hffff};
        vtab[3].wr = {16'h0000, 16'h4000, 16'h4000};
        vtab[3].wi = {16'h0000, 16'hc000, 16'h4000};
        vtab[3].er = {16'h0000, D2R, 16'h0800, 16'h0001};
        vtab[3].ei = {16'h0000, D2I, 16'h1800, 16'hffff};
        // V4: lane 0 only
        vtab[4].xr[0] = 16'h00aa; vtab[4].xi[0] = 16'h0055;
        vtab[4].er[0] = 16'h00aa; vtab[4].ei[0] = 16'h0055;

        in_valid = 1'b0; in_sof = 1'b0;
        {in0_r, in0_i, in1_r, in1_i, in2_r, in2_i, in3_r, in3_i} = '0;
        {tw1_r, tw1_i, tw2_r, tw2_i, tw3_r, tw3_i} = '0;
        rst = 1'b1;
        idle(2);
        chk_idx(2'd0, "reset_tw_index");
        rst = 1'b0;

        // frame: 0,1,2,3 then natural wrap to 0
        send(0, 1'b1, 2'd0, 1'b1, 1'b0);
        send(1, 1'b0, 2'd1, 1'b1, 1'b0);
        send(2, 1'b0, 2'd2, 1'b1, 1'b0);
        send(3, 1'b0, 2'd3, 1'b1, 1'b0);
        send(4, 1'b0, 2'd0, 1'b1, 1'b0);
        // mid-frame sof restarts at 0
        send(0, 1'b1, 2'd0, 1'b1, 1'b0);
        send(1, 1'b0, 2'd1, 1'b1, 1'b0);
        // sof without valid is ignored
        in_sof = 1'b1;
        #1;
        chk_idx(2'd2, "sof_no_valid");
        @(posedge clk);
        #1;
        in_sof = 1'b0;
        // sparse traffic, index advances only on valid beats
        send(2, 1'b0, 2'd2, 1'b1, 1'b0); idle(1);
        send(3, 1'b0, 2'd3, 1'b1, 1'b0); idle(1);
        send(1, 1'b0, 2'd0, 1'b1, 1'b0); idle(1);
        send(0, 1'b0, 2'd1, 1'b1, 1'b0); idle(1);
        idle(6);
        // reset with three samples in flight, starting at grp=2
        send(1, 1'b0, 2'd2, 1'b0, 1'b0);
        send(2, 1'b0, 2'd3, 1'b0, 1'b0);
        send(3, 1'b0, 2'd0, 1'b0, 1'b1);
        idle(2);
        send(3, 1'b0, 2'd0, 1'b1, 1'b0);
        idle(8);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
